// File: rtl/seg_scan_if.sv
// Time-load and display bundle for the four-digit multiplexed clock display.
// master = source of time and blanking control; slave = the scan driver.
interface seg_scan_if;
    logic       time_vld;
    logic [4:0] hours_in;
    logic [5:0] minutes_in;
    logic       blank_lz;
    logic [6:0] seg;
    logic [3:0] dig_sel;
    logic       busy;
    logic       err;

    modport master (
        output time_vld, hours_in, minutes_in, blank_lz,
        input  seg, dig_sel, busy, err
    );

    modport slave (
        input  time_vld, hours_in, minutes_in, blank_lz,
        output seg, dig_sel, busy, err
    );
endinterface

// File: rtl/seg_scan_driver.sv
// HH:MM binary-to-BCD converter (repeated subtraction) feeding a time-multiplexed
// four-digit 7-segment scanner with optional hours leading-zero blanking.
module seg_scan_driver #(
    parameter int SCAN_DIV = 27000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    seg_scan_if.slave  bus
);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV_H,
        ST_CONV_M,
        ST_COMMIT
    } state_t;

    state_t             state_q, state_d;
    logic [4:0]         h_rem_q, h_rem_d;
    logic [1:0]         h_tens_q, h_tens_d;
    logic [5:0]         m_rem_q, m_rem_d;
    logic [2:0]         m_tens_q, m_tens_d;
    logic               err_q, err_d;
    logic [3:0][3:0]    disp_q, disp_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [1:0]         idx_q, idx_d;
    logic [6:0]         seg_q, seg_d;
    logic [3:0]         dig_sel_q, dig_sel_d;
    logic [6:0]         digit_seg [4];

    function automatic logic [6:0] decode7(input logic [3:0] d);
        case (d)
            4'd0:    decode7 = 7'h3F;
            4'd1:    decode7 = 7'h06;
            4'd2:    decode7 = 7'h5B;
            4'd3:    decode7 = 7'h4F;
            4'd4:    decode7 = 7'h66;
            4'd5:    decode7 = 7'h6D;
            4'd6:    decode7 = 7'h7D;
            4'd7:    decode7 = 7'h07;
            4'd8:    decode7 = 7'h7F;
            4'd9:    decode7 = 7'h6F;
            default: decode7 = 7'h00;
        endcase
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dec
            assign digit_seg[gi] = decode7(disp_q[gi]);
        end
    endgenerate

    // Conversion FSM: one subtract-by-ten step per cycle, then a single atomic commit.
    always_comb begin
        state_d  = state_q;
        h_rem_d  = h_rem_q;
        h_tens_d = h_tens_q;
        m_rem_d  = m_rem_q;
        m_tens_d = m_tens_q;
        err_d    = err_q;
        disp_d   = disp_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.time_vld) begin
                    if (bus.hours_in <= 5'd23 && bus.minutes_in <= 6'd59) begin
                        h_rem_d  = bus.hours_in;
                        h_tens_d = '0;
                        m_rem_d  = bus.minutes_in;
                        m_tens_d = '0;
                        err_d    = 1'b0;
                        state_d  = ST_CONV_H;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_CONV_H: begin
                if (h_rem_q >= 5'd10) begin
                    h_rem_d  = h_rem_q - 5'd10;
                    h_tens_d = h_tens_q + 2'd1;
                end else begin
                    state_d = ST_CONV_M;
                end
            end
            ST_CONV_M: begin
                if (m_rem_q >= 6'd10) begin
                    m_rem_d  = m_rem_q - 6'd10;
                    m_tens_d = m_tens_q + 3'd1;
                end else begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                disp_d[0] = {2'b00, h_tens_q};
                disp_d[1] = h_rem_q[3:0];
                disp_d[2] = {1'b0, m_tens_q};
                disp_d[3] = m_rem_q[3:0];
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Scanner runs independently of the converter and only ever sees committed digits.
    always_comb begin
        div_d = div_q + 1'b1;
        idx_d = idx_q;
        if (div_q == DIV_W'(SCAN_DIV - 1)) begin
            div_d = '0;
            idx_d = idx_q + 2'd1;
        end
        seg_d = digit_seg[idx_q];
        if (bus.blank_lz && idx_q == 2'd0 && disp_q[0] == 4'd0) begin
            seg_d = 7'h00;
        end
        dig_sel_d = 4'b0001 << idx_q;
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q   <= ST_IDLE;
            h_rem_q   <= '0;
            h_tens_q  <= '0;
            m_rem_q   <= '0;
            m_tens_q  <= '0;
            err_q     <= 1'b0;
            disp_q    <= '0;
            div_q     <= '0;
            idx_q     <= '0;
            seg_q     <= 7'h00;
            dig_sel_q <= 4'b0001;
        end else begin
            state_q   <= state_d;
            h_rem_q   <= h_rem_d;
            h_tens_q  <= h_tens_d;
            m_rem_q   <= m_rem_d;
            m_tens_q  <= m_tens_d;
            err_q     <= err_d;
            disp_q    <= disp_d;
            div_q     <= div_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            dig_sel_q <= dig_sel_d;
        end
    end

    assign bus.seg     = seg_q;
    assign bus.dig_sel = dig_sel_q;
    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.err     = err_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized + directed bench for seg_scan_driver against a timing-level model of
// committed digits, busy window, error flag and scan slot derived from cycle count.
module tb_seg_scan_driver;
    localparam int SCAN_DIV = 4;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    bit   blank     = 1'b0;

    seg_scan_if bus ();

    seg_scan_driver #(.SCAN_DIV(SCAN_DIV)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state
    int         k;
    int         busy_left;
    int         disp [4];
    int         pend [4];
    bit         m_err;
    logic [6:0] m_seg;
    logic [3:0] m_dig;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] tbl [10];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return tbl[d];
    endfunction

    // One clock: drive at negedge, update model at posedge, check outputs shortly after.
    task automatic cycle(input bit rst_n, input bit vld, input int h, input int m);
        int slot;
        sys_rst_n      = rst_n;
        bus.time_vld   = vld;
        bus.hours_in   = h[4:0];
        bus.minutes_in = m[5:0];
        bus.blank_lz   = blank;
        @(posedge sys_clk);
        if (!rst_n) begin
            k = 0;
            busy_left = 0;
            for (int i = 0; i < 4; i++) disp[i] = 0;
            m_err = 1'b0;
            m_seg = 7'h00;
            m_dig = 4'b0001;
        end else begin
            k++;
            slot  = ((k - 1) / SCAN_DIV) % 4;
            m_dig = 4'(1 << slot);
            m_seg = (slot == 0 && blank && disp[0] == 0) ? 7'h00 : seg_of(disp[slot]);
            if (busy_left > 0) begin
                if (vld) $display("strobe %0d:%0d ignored (busy)", h, m);
                busy_left--;
                if (busy_left == 0) disp = pend;
            end else if (vld) begin
                if (h <= 23 && m <= 59) begin
                    pend = '{h / 10, h % 10, m / 10, m % 10};
                    busy_left = (h / 10 + 1) + (m / 10 + 1) + 1;
                    m_err = 1'b0;
                    $display("strobe %0d:%0d accepted, busy %0d cycles", h, m, busy_left);
                end else begin
                    m_err = 1'b1;
                    $display("strobe %0d:%0d rejected (out of range)", h, m);
                end
            end
        end
        #1;
        check_val("seg", 32'(bus.seg), 32'(m_seg));
        check_val("dig_sel", 32'(bus.dig_sel), 32'(m_dig));
        check_val("busy", 32'(bus.busy), 32'(busy_left > 0));
        check_val("err", 32'(bus.err), 32'(m_err));
        @(negedge sys_clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 0, 0);
    endtask

    initial begin
        int cnt;
        bus.time_vld = 1'b0;
        bus.hours_in = '0;
        bus.minutes_in = '0;
        bus.blank_lz = 1'b0;

        // Reset and first edge after release
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 0, 0);
        cycle(1'b1, 1'b0, 0, 0);
        check_val("rst_rel_seg", 32'(bus.seg), 32'h3F);
        idle(3);

        // 23:59 -> ten busy cycles, then scan through all four slots
        cycle(1'b1, 1'b1, 23, 59);
        cnt = 0;
        while (bus.busy && cnt < 50) begin
            cnt++;
            cycle(1'b1, 1'b0, 0, 0);
        end
        check_val("busy_len", 32'(cnt), 32'd10);
        idle(20);

        // Out-of-range then legal strobe
        cycle(1'b1, 1'b1, 24, 0);
        check_val("err_set", 32'(bus.err), 32'd1);
        idle(6);
        cycle(1'b1, 1'b1, 1, 0);
        check_val("err_clr", 32'(bus.err), 32'd0);
        idle(20);

        // Strobe during conversion is ignored
        cycle(1'b1, 1'b1, 12, 34);
        cycle(1'b1, 1'b0, 0, 0);
        cycle(1'b1, 1'b1, 5, 5);
        idle(25);

        // Leading-zero blanking
        blank = 1'b1;
        cycle(1'b1, 1'b1, 7, 5);
        idle(25);
        blank = 1'b0;
        idle(4);

        // Reset mid CONV_M abandons the conversion
        cycle(1'b1, 1'b1, 12, 34);
        idle(4);
        cycle(1'b0, 1'b0, 0, 0);
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        idle(30);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 63) == 0) blank = ~blank;
            if ($urandom_range(0, 299) == 0)
                cycle(1'b0, 1'b0, 0, 0);
            else if ($urandom_range(0, 7) == 0)
                cycle(1'b1, 1'b1, int'($urandom_range(0, 31)), int'($urandom_range(0, 63)));
            else
                cycle(1'b1, 1'b0, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
